// File: rtl/pps_interval_meter.sv
// Measures clock counts between rising edges on NCH asynchronous PPS inputs and reports them
// via a round-robin valid/ready record port. Define PPS_MISSING_DET_EN for missing-pulse timeouts.
`timescale 1ns/1ps
module pps_interval_meter #(
    parameter int NCH      = 4,
    parameter int CNT_BITS = 32,
    parameter int NOMINAL  = 156250000,
    parameter int TOL      = 1000,
    parameter int LOCK_CNT = 4,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NCH-1:0]      i_pps,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [CW-1:0]       o_chan,
    output logic [CNT_BITS-1:0] o_period,
    output logic [2:0]          o_flags,
    output logic [NCH-1:0]      o_locked
);

    localparam logic [CNT_BITS:0] NOM_X  = (CNT_BITS+1)'(NOMINAL);
    localparam logic [CNT_BITS:0] TOL_X  = (CNT_BITS+1)'(TOL);
    localparam logic [3:0]        LOCK_X = 4'(LOCK_CNT);
`ifdef PPS_MISSING_DET_EN
    localparam logic [CNT_BITS:0] TO_X   = NOM_X + TOL_X + (CNT_BITS+1)'(1);
`endif

    // Tolerance test done one bit wider so neither subtraction can wrap.
    function automatic logic f_in_tol(input logic [CNT_BITS-1:0] per);
        logic [CNT_BITS:0] ext;
        logic [CNT_BITS:0] diff;
        ext  = {1'b0, per};
        diff = (ext >= NOM_X) ? (ext - NOM_X) : (NOM_X - ext);
        return (diff <= TOL_X);
    endfunction

    function automatic logic [CNT_BITS-1:0] f_sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : (v + CNT_BITS'(1));
    endfunction

    logic [NCH-1:0]      r_sync1, r_sync2, r_sync3, r_edge, r_armed;
    logic [CNT_BITS-1:0] r_cnt [NCH];
    logic [3:0]          r_lock [NCH];
    logic [NCH-1:0]      r_slot_vld, r_slot_ovr, r_slot_tol, r_slot_to;
    logic [CNT_BITS-1:0] r_slot_per [NCH];
    logic [CW-1:0]       r_last;
    logic                r_valid;
    logic [CW-1:0]       r_chan;
    logic [CNT_BITS-1:0] r_period;
    logic [2:0]          r_flags;

    logic [CNT_BITS:0]   w_per_ext [NCH];
    logic [CNT_BITS-1:0] w_per [NCH];
    logic [CNT_BITS-1:0] w_new_per [NCH];
    logic [NCH-1:0]      w_tol, w_cap, w_to, w_drain;
    logic                w_load;
    logic                w_gnt_vld, w_gnt_hi_vld, w_gnt_lo_vld;
    logic [CW-1:0]       w_gnt, w_gnt_hi, w_gnt_lo;

    assign w_load = ~r_valid | i_ready;

    genvar n;
    for (n = 0; n < NCH; n++) begin : g_ch
        assign w_per_ext[n] = {1'b0, r_cnt[n]} + (CNT_BITS+1)'(1);
        assign w_per[n]     = w_per_ext[n][CNT_BITS] ? '1 : w_per_ext[n][CNT_BITS-1:0];
        assign w_tol[n]     = f_in_tol(w_per[n]);
        assign w_cap[n]     = r_edge[n] & r_armed[n];
        assign w_drain[n]   = w_load & w_gnt_vld & (w_gnt == CW'(n));
        assign o_locked[n]  = (r_lock[n] == LOCK_X);
`ifdef PPS_MISSING_DET_EN
        // Fires on the cycle an edge would first have produced an over-long period.
        assign w_to[n]      = r_armed[n] & ~r_edge[n] & (w_per_ext[n] == TO_X);
        assign w_new_per[n] = w_cap[n] ? w_per[n] : TO_X[CNT_BITS-1:0];
`else
        assign w_to[n]      = 1'b0;
        assign w_new_per[n] = w_per[n];
`endif
    end

    // Round-robin: lowest pending channel above the last grant wins, else wrap to the lowest.
    always_comb begin
        w_gnt_hi_vld = 1'b0;
        w_gnt_hi     = '0;
        w_gnt_lo_vld = 1'b0;
        w_gnt_lo     = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (r_slot_vld[j]) begin
                if (j > int'(r_last)) begin
                    w_gnt_hi_vld = 1'b1;
                    w_gnt_hi     = CW'(j);
                end else begin
                    w_gnt_lo_vld = 1'b1;
                    w_gnt_lo     = CW'(j);
                end
            end
        end
        w_gnt_vld = w_gnt_hi_vld | w_gnt_lo_vld;
        w_gnt     = w_gnt_hi_vld ? w_gnt_hi : w_gnt_lo;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync3    <= '0;
            r_edge     <= '0;
            r_armed    <= '0;
            r_slot_vld <= '0;
            r_slot_ovr <= '0;
            r_slot_tol <= '0;
            r_slot_to  <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i]      <= '0;
                r_lock[i]     <= '0;
                r_slot_per[i] <= '0;
            end
        end else begin
            r_sync1 <= i_pps;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= r_sync2 & ~r_sync3;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= r_edge[i] ? '0 : f_sat_inc(r_cnt[i]);
                if (r_edge[i]) begin
                    r_armed[i] <= 1'b1;
                end else if (w_to[i]) begin
                    r_armed[i] <= 1'b0;
                end
                // A capture that lands on an undrained slot overwrites it and flags the loss.
                if (w_cap[i] || w_to[i]) begin
                    r_slot_vld[i] <= 1'b1;
                    r_slot_ovr[i] <= r_slot_vld[i] & ~w_drain[i];
                    r_slot_tol[i] <= w_cap[i] & w_tol[i];
                    r_slot_to[i]  <= w_to[i];
                    r_slot_per[i] <= w_new_per[i];
                end else if (w_drain[i]) begin
                    r_slot_vld[i] <= 1'b0;
                end
                if (w_to[i] || (w_cap[i] && !w_tol[i])) begin
                    r_lock[i] <= '0;
                end else if (w_cap[i] && (r_lock[i] != LOCK_X)) begin
                    r_lock[i] <= r_lock[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid  <= 1'b0;
            r_chan   <= '0;
            r_period <= '0;
            r_flags  <= '0;
            r_last   <= CW'(NCH - 1);
        end else if (w_load) begin
            r_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_chan   <= w_gnt;
                r_period <= r_slot_per[w_gnt];
                r_flags  <= {r_slot_to[w_gnt], r_slot_ovr[w_gnt], r_slot_tol[w_gnt]};
                r_last   <= w_gnt;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_chan   = r_chan;
    assign o_period = r_period;
    assign o_flags  = r_flags;

endmodule

// File: tb/tb_pps_interval_meter.sv
// Self-checking bench for pps_interval_meter: random and directed PPS edge schedules
// compared against an edge-time based record model.
`timescale 1ns/1ps
module tb_pps_interval_meter;
    localparam int NCH = 4;
    localparam int NOM = 1000;
    localparam int TOLR = 2;
    localparam int LOCKN = 4;
`ifdef PPS_MISSING_DET_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NCH-1:0]  pps;
    logic            rdy;
    logic            o_valid;
    logic [1:0]      o_chan;
    logic [31:0]     o_period;
    logic [2:0]      o_flags;
    logic [NCH-1:0]  o_locked;

    int total = 0;
    int bad = 0;
    int unsigned cyc = 0;

    typedef struct {
        int       chan;
        int       period;
        logic [2:0] flags;
        bit       lk;
        int unsigned t;
    } rec_t;
    rec_t rq[$];
    rec_t eq[$];

    pps_interval_meter #(.NCH(NCH), .CNT_BITS(32), .NOMINAL(NOM), .TOL(TOLR), .LOCK_CNT(LOCKN)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pps(pps), .o_valid(o_valid), .i_ready(rdy),
        .o_chan(o_chan), .o_period(o_period), .o_flags(o_flags), .o_locked(o_locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && o_valid && rdy)
            rq.push_back('{chan: int'(o_chan), period: int'(o_period), flags: o_flags,
                           lk: o_locked[o_chan], t: cyc});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_gap(input logic [NCH-1:0] m, input int g);
        pps = m;
        repeat (4) step();
        pps = '0;
        repeat (g - 4) step();
    endtask

    task automatic run_chan(input int ch, input int gaps[$]);
        foreach (gaps[i]) pulse_gap(4'(1 << ch), gaps[i]);
        pulse_gap(4'(1 << ch), 30);
    endtask

    // Reference: a record per gap between consecutive edges; a gap longer than NOM+TOL
    // becomes a timeout record when detection is built in, and the closing edge only re-arms.
    task automatic model_chan(input int ch, input int gaps[$], output bit lk_final);
        int lk = 0;
        foreach (gaps[i]) begin
            int  g = gaps[i];
            bit  tol;
            if (TO_EN && g > NOM + TOLR) begin
                lk = 0;
                eq.push_back('{chan: ch, period: NOM + TOLR + 1, flags: 3'b100, lk: 1'b0, t: 0});
            end else begin
                tol = ((g > NOM) ? g - NOM : NOM - g) <= TOLR;
                lk = tol ? ((lk < LOCKN) ? lk + 1 : LOCKN) : 0;
                eq.push_back('{chan: ch, period: g, flags: {2'b00, tol}, lk: (lk == LOCKN), t: 0});
            end
        end
        lk_final = (lk == LOCKN);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pps = '0;
        rdy = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        rq.delete();
        eq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pps = '0;
        rdy = 1'b1;
        repeat (2) step();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", o_valid); end
        total++; if (o_chan !== 2'd0) begin bad++; $display("FAIL reset_chan got=%0h exp=0", o_chan); end
        total++; if (o_period !== 32'd0) begin bad++; $display("FAIL reset_period got=%0h exp=0", o_period); end
        total++; if (o_flags !== 3'd0) begin bad++; $display("FAIL reset_flags got=%0h exp=0", o_flags); end
        total++; if (o_locked !== 4'd0) begin bad++; $display("FAIL reset_locked got=%0h exp=0", o_locked); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_latency();
        do_reset();
        pulse_gap(4'b0001, 500);
        pps = 4'b0001;
        for (int j = 0; j <= 4; j++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (o_valid !== (j == 4)) begin
                bad++;
                $display("FAIL latency_k+%0d got=%0b exp=%0b", j, o_valid, (j == 4));
            end
        end
        step();
        pps = '0;
        repeat (20) step();
        total++;
        if (rq.size() != 1 || rq[0].period != 500) begin
            bad++;
            $display("FAIL latency_record got_n=%0d exp_n=1 exp_period=500", rq.size());
        end
    endtask

    task automatic test_lock_relock();
        int g[$];
        bit lf;
        do_reset();
        g = '{1000, 1000, 1000, 1000, 1000, 1005, 1000, 1000, 1000, 1000};
        model_chan(0, g, lf);
        run_chan(0, g);
        total++;
        if (rq.size() != eq.size()) begin
            bad++; $display("FAIL lock_count got=%0d exp=%0d", rq.size(), eq.size());
        end
        for (int i = 0; i < rq.size() && i < eq.size(); i++) begin
            total++;
            if (rq[i].chan != eq[i].chan || rq[i].period != eq[i].period ||
                rq[i].flags !== eq[i].flags || rq[i].lk != eq[i].lk) begin
                bad++;
                $display("FAIL lock_rec%0d got=ch%0d/%0d/%b/lk%0b exp=ch%0d/%0d/%b/lk%0b", i,
                         rq[i].chan, rq[i].period, rq[i].flags, rq[i].lk,
                         eq[i].chan, eq[i].period, eq[i].flags, eq[i].lk);
            end
        end
        total++;
        if (o_locked[0] !== lf) begin bad++; $display("FAIL lock_final got=%0b exp=%0b", o_locked[0], lf); end
    endtask

    task automatic test_missing_pulse();
        int g[$];
        bit lf;
        do_reset();
        g = '{1000, 1000, 1000, 1000, 1000, 1200};
        model_chan(2, g, lf);
        run_chan(2, g);
        total++;
        if (rq.size() != eq.size()) begin
            bad++; $display("FAIL missing_count got=%0d exp=%0d", rq.size(), eq.size());
        end
        for (int i = 0; i < rq.size() && i < eq.size(); i++) begin
            total++;
            if (rq[i].chan != eq[i].chan || rq[i].period != eq[i].period ||
                rq[i].flags !== eq[i].flags || rq[i].lk != eq[i].lk) begin
                bad++;
                $display("FAIL missing_rec%0d got=ch%0d/%0d/%b/lk%0b exp=ch%0d/%0d/%b/lk%0b", i,
                         rq[i].chan, rq[i].period, rq[i].flags, rq[i].lk,
                         eq[i].chan, eq[i].period, eq[i].flags, eq[i].lk);
            end
        end
        total++;
        if (o_locked[2] !== lf) begin bad++; $display("FAIL missing_lock got=%0b exp=%0b", o_locked[2], lf); end
    endtask

    task automatic test_round_robin();
        int exp_ch[8] = '{0, 1, 2, 3, 1, 2, 0, 1};
        int exp_pe[8] = '{500, 500, 500, 500, 300, 600, 600, 300};
        do_reset();
        pulse_gap(4'b1111, 500);
        pulse_gap(4'b1111, 300);
        pulse_gap(4'b0010, 300);
        pulse_gap(4'b0111, 30);
        total++;
        if (rq.size() != 8) begin bad++; $display("FAIL rr_count got=%0d exp=8", rq.size()); end
        for (int i = 0; i < 8 && i < rq.size(); i++) begin
            total++;
            if (rq[i].chan != exp_ch[i] || rq[i].period != exp_pe[i]) begin
                bad++;
                $display("FAIL rr_rec%0d got=ch%0d/%0d exp=ch%0d/%0d", i,
                         rq[i].chan, rq[i].period, exp_ch[i], exp_pe[i]);
            end
        end
        if (rq.size() == 8) begin
            total++;
            if (rq[3].t != rq[0].t + 3 || rq[7].t != rq[5].t + 2) begin
                bad++;
                $display("FAIL rr_back_to_back got=%0d,%0d,%0d,%0d exp=consecutive",
                         rq[0].t, rq[3].t, rq[5].t, rq[7].t);
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        pulse_gap(4'b0010, 1000);
        rdy = 1'b0;
        pulse_gap(4'b0010, 999);
        pulse_gap(4'b0010, 1001);
        pulse_gap(4'b0010, 20);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total++;
            if (o_valid !== 1'b1 || o_chan !== 2'd1 || o_period !== 32'd1000 || o_flags !== 3'b001) begin
                bad++;
                $display("FAIL stall_hold got=%0b/%0d/%0d/%b exp=1/1/1000/001",
                         o_valid, o_chan, o_period, o_flags);
            end
            step();
        end
        rdy = 1'b1;
        repeat (10) step();
        total++;
        if (rq.size() != 2) begin bad++; $display("FAIL overrun_count got=%0d exp=2", rq.size()); end
        if (rq.size() >= 2) begin
            total++;
            if (rq[1].chan != 1 || rq[1].period != 1001 || rq[1].flags !== 3'b011) begin
                bad++;
                $display("FAIL overrun_rec got=ch%0d/%0d/%b exp=ch1/1001/011",
                         rq[1].chan, rq[1].period, rq[1].flags);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_gap(4'b1111, 500);
        rdy = 1'b0;
        pulse_gap(4'b1111, 40);
        total++;
        if (o_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%0b exp=1", o_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_valid, o_chan, o_period, o_flags, o_locked} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs got=%0b/%0d/%0d/%b/%b exp=all0",
                     o_valid, o_chan, o_period, o_flags, o_locked);
        end
        repeat (3) step();
        rst_n = 1'b1;
        rdy = 1'b1;
        rq.delete();
        repeat (100) step();
        pulse_gap(4'b0001, 500);
        total++;
        if (rq.size() != 0) begin bad++; $display("FAIL midrst_stale got=%0d exp=0", rq.size()); end
        pulse_gap(4'b0001, 20);
        total++;
        if (rq.size() != 1 || rq[0].period != 500) begin
            bad++; $display("FAIL midrst_after got_n=%0d exp_n=1 exp_period=500", rq.size());
        end
    endtask

    task automatic test_random();
        int et[NCH][$];
        int g[NCH][$];
        bit lf[NCH];
        int tmax = 0;
        do_reset();
        for (int n = 0; n < NCH; n++) begin
            et[n].push_back($urandom_range(5, 200));
            for (int k = 0; k < 6; k++) begin
                int gap;
                gap = ($urandom_range(0, 9) == 0) ? 1010 : $urandom_range(990, 1002);
                g[n].push_back(gap);
                et[n].push_back(et[n][et[n].size()-1] + gap);
            end
            model_chan(n, g[n], lf[n]);
            if (et[n][et[n].size()-1] > tmax) tmax = et[n][et[n].size()-1];
        end
        for (int t = 0; t <= tmax + 40; t++) begin
            for (int n = 0; n < NCH; n++) begin
                pps[n] = 1'b0;
                foreach (et[n][k]) if (t >= et[n][k] && t < et[n][k] + 4) pps[n] = 1'b1;
            end
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        rdy = 1'b1;
        repeat (10) step();
        for (int n = 0; n < NCH; n++) begin
            rec_t a[$];
            rec_t b[$];
            a = rq.find with (item.chan == n);
            b = eq.find with (item.chan == n);
            total++;
            if (a.size() != b.size()) begin
                bad++; $display("FAIL rand_ch%0d_count got=%0d exp=%0d", n, a.size(), b.size());
            end
            for (int i = 0; i < a.size() && i < b.size(); i++) begin
                total++;
                if (a[i].period != b[i].period || a[i].flags !== b[i].flags || a[i].lk != b[i].lk) begin
                    bad++;
                    $display("FAIL rand_ch%0d_rec%0d got=%0d/%b/lk%0b exp=%0d/%b/lk%0b", n, i,
                             a[i].period, a[i].flags, a[i].lk, b[i].period, b[i].flags, b[i].lk);
                end
            end
            total++;
            if (o_locked[n] !== lf[n]) begin
                bad++; $display("FAIL rand_ch%0d_locked got=%0b exp=%0b", n, o_locked[n], lf[n]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pps = '0;
        rdy = 1'b1;
        test_reset();
        test_latency();
        test_lock_relock();
        test_missing_pulse();
        test_round_robin();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pps_interval_meter.md
PPS_INTERVAL_METER -- requirements
Module: pps_interval_meter

Interface
REQ-001 Parameter NCH, default 4, number of independent PPS input channels (1..16).
REQ-002 Parameter CNT_BITS, default 32, width of per-channel interval counters and reported period.
REQ-003 Parameter NOMINAL, default 156250000, expected clocks between PPS edges.
REQ-004 Parameter TOL, default 1000, allowed |period - NOMINAL| in clocks.
REQ-005 Parameter LOCK_CNT, default 4, consecutive in-tolerance periods to declare lock (1..15).
REQ-006 i_clk  input  1  sole clock; all state on its rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_pps  input  NCH  asynchronous PPS inputs, one bit per channel.
REQ-009 o_valid  output  1  measurement record available.
REQ-010 i_ready  input  1  consumer accepts record when high with o_valid.
REQ-011 o_chan  output  max(1,clog2(NCH))  channel index of record.
REQ-012 o_period  output  CNT_BITS  measured clocks between successive edges.
REQ-013 o_flags  output  3  {timeout, overrun, in_tol}.
REQ-014 o_locked  output  NCH  per-channel lock status.

Function
REQ-015 Each i_pps bit passes a 2-FF synchroniser; a rising edge is sync2 high with sync3 low.
REQ-016 Per-channel counter clears to 0 on edge cycle, else increments, saturating at all-ones.
REQ-017 First edge after reset (or after timeout) only arms the channel; no record produced.
REQ-018 Each subsequent edge captures period = counter + 1 into that channel's one-entry pending slot.
REQ-019 in_tol set when |period - NOMINAL| <= TOL, computed at CNT_BITS+1 width without wrap.
REQ-020 Lock counter increments on in_tol capture, saturating at LOCK_CNT; any out-of-tol capture or timeout clears it to 0; o_locked[n] high iff counter == LOCK_CNT.
REQ-021 Capture into a full slot not drained that cycle overwrites it and sets overrun; capture coinciding with drain of same slot loads new record with overrun clear.
REQ-022 Output register loads from pending slots by round-robin, searching from channel after last granted; after reset channel 0 has priority.
REQ-023 Output register refills in the same cycle it is empty or transferring (o_valid & i_ready), giving one cycle slot-to-output latency.
REQ-024 o_chan, o_period, o_flags SHALL stay stable while o_valid high and i_ready low.
REQ-025 Latency: i_pps high sampled at clock k, no contention, empty output -> o_valid high after clock k+4.
REQ-026 Simultaneous edges on several channels each capture into own slot; drained one per transfer in round-robin order, none lost.

Reset
REQ-027 i_rst_n low SHALL immediately clear synchronisers, counters, armed bits, slots, lock counters, round-robin pointer.
REQ-028 During and after reset: o_valid=0, o_chan=0, o_period=0, o_flags=0, o_locked=0; reset mid-operation discards pending records.

Configuration
REQ-029 Macro PPS_MISSING_DET_EN compiles in missing-pulse detection.
REQ-030 With macro: armed channel whose counter reaches NOMINAL+TOL+1 without edge produces record period=NOMINAL+TOL+1, flags timeout=1 in_tol=0, clears lock, disarms.
REQ-031 Without macro: no timeout records; timeout flag constant 0; counter saturates; late edge yields ordinary out-of-tol record.

Verification
REQ-032 NOMINAL=1000,TOL=2: ch0 edges every 1000 clocks, i_ready=1 -> first edge no record, then period=1000, flags=001, o_locked[0] high after 4th record.
REQ-033 Same ch0 with one 1005-clock gap -> record period=1005, flags=000, o_locked[0] drops next cycle, relocks after 4 good periods.
REQ-034 Edges on ch0..ch3 same cycle, i_ready=1 -> four records o_chan 0,1,2,3 on consecutive cycles.
REQ-035 i_ready=0 across two ch1 periods, then 1 -> single ch1 record, flags overrun=1, period=latest value.
REQ-036 With PPS_MISSING_DET_EN, ch2 stops after lock -> record period=1003, flags=100, o_locked[2]=0; next edge arms only; without macro no record.
REQ-037 Assert i_rst_n low while records pending and o_valid high -> all outputs 0 immediately, no records after release until two new edges.
